// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART packet receiver: FSM states, error causes,
// checksum mode selectors and a ceil-log2 helper for sizing counters.
package uart_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK,
        S_SKIP
    } rx_state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'd0;
    localparam err_code_t ERR_CHK  = 2'd1;
    localparam err_code_t ERR_LEN  = 2'd2;
    localparam err_code_t ERR_TO   = 2'd3;

    localparam int CHK_SUM = 0;
    localparam int CHK_XOR = 1;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte idle counter: counts enabled, uncleared cycles and pulses expire_o on
// the cycle that would reach TIMEOUT_CYC, then restarts from zero.
module rx_timeout_cnt
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = clogb2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A byte in the expiry cycle clears the counter and suppresses the abort.
    assign expire_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_packet_parser.sv
// UART packet receiver: parses CMD / LEN / payload / CHK frames, streams payload bytes
// to RAM with indices, verifies the checksum and reports done or error with a cause.
module rx_packet_parser
    import uart_pkg::*;
#(
    parameter  int MAX_LEN     = 256,
    parameter  int LEN_BYTES   = 1,
    parameter  int TIMEOUT_CYC = 50000,
    parameter  int CHK_MODE    = 0,
    localparam int ADDR_W      = clogb2(MAX_LEN),
    // Wide enough for both the raw LEN field and the value MAX_LEN itself.
    localparam int LEN_W       = (8 * LEN_BYTES > ADDR_W + 1) ? 8 * LEN_BYTES : ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        cmd_rx,
    output logic [LEN_W-1:0]  len_rx,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              we,
    output logic              pck_done,
    output logic              pck_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int               LENF_W    = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [ADDR_W:0]  ADDR_ONE  = (ADDR_W + 1)'(1);

    rx_state_t         state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [LENF_W-1:0] lenf_q, lenf_d;
    logic [1:0]        lenidx_q, lenidx_d;
    logic [LEN_W-1:0]  lenrx_q, lenrx_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_code_t         errc_q, errc_d;

    logic [LENF_W-1:0] lenf_sh;
    logic [LEN_W-1:0]  len_dec;
    logic [ADDR_W:0]   addr_nxt;
    logic              expire;

    function automatic logic [7:0] acc_upd(input logic [7:0] a, input logic [7:0] b);
        return (CHK_MODE == CHK_XOR) ? (a ^ b) : (a + b);
    endfunction

    function automatic logic [7:0] chk_exp(input logic [7:0] a);
        return (CHK_MODE == CHK_XOR) ? a : ~a;
    endfunction

    generate
        if (TIMEOUT_CYC != 0) begin : g_timeout
            rx_timeout_cnt #(
                .TIMEOUT_CYC(TIMEOUT_CYC)
            ) u_timeout (
                .clk     (clk),
                .reset_n (reset_n),
                .clr_i   (rx_valid),
                .en_i    (state_q != S_CMD),
                .expire_o(expire)
            );
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        lenf_d   = lenf_q;
        lenidx_d = lenidx_q;
        lenrx_d  = lenrx_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        errc_d   = errc_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        lenf_sh  = (lenf_q << 8) | LENF_W'(rx_data);
        len_dec  = (lenf_sh == '0) ? MAX_LEN_L : LEN_W'(lenf_sh);
        addr_nxt = addr_q + ADDR_ONE;

        case (state_q)
            S_CMD: begin
                if (rx_valid) begin
                    cmd_d    = rx_data;
                    acc_d    = rx_data;
                    lenidx_d = 2'd0;
                    lenf_d   = '0;
                    state_d  = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    acc_d  = acc_upd(acc_q, rx_data);
                    lenf_d = lenf_sh;
                    if (lenidx_q == 2'(LEN_BYTES - 1)) begin
                        if (len_dec > MAX_LEN_L) begin
                            err_d   = 1'b1;
                            errc_d  = ERR_LEN;
                            state_d = S_SKIP;
                        end else begin
                            lenrx_d = len_dec;
                            addr_d  = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        lenidx_d = lenidx_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data;
                    waddr_d = addr_q[ADDR_W-1:0];
                    acc_d   = acc_upd(acc_q, rx_data);
                    addr_d  = addr_nxt;
                    if (LEN_W'(addr_nxt) == lenrx_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_exp(acc_q)) begin
                        done_d = 1'b1;
                        errc_d = ERR_NONE;
                    end else begin
                        err_d  = 1'b1;
                        errc_d = ERR_CHK;
                    end
                    state_d = S_CMD;
                end
            end
            default: begin
            end
        endcase

        // Oversize frames already reported their error; expiry there just resyncs.
        if (expire) begin
            state_d = S_CMD;
            if (state_q != S_SKIP) begin
                err_d  = 1'b1;
                errc_d = ERR_TO;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_CMD;
            cmd_q    <= '0;
            lenf_q   <= '0;
            lenidx_q <= '0;
            lenrx_q  <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            waddr_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            lenf_q   <= lenf_d;
            lenidx_q <= lenidx_d;
            lenrx_q  <= lenrx_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    assign cmd_rx   = cmd_q;
    assign len_rx   = lenrx_q;
    assign wr_data  = wdata_q;
    assign wr_addr  = waddr_q;
    assign we       = we_q;
    assign pck_done = done_q;
    assign pck_err  = err_q;
    assign err_code = errc_q;
    assign busy     = (state_q != S_CMD);

endmodule

// File: tb/tb_rx_packet_parser.sv
// Scoreboard bench for rx_packet_parser: four parameterisations share one clock and
// reset; expected RAM writes and done/error pulses are queued as frames are driven.
module tb_rx_packet_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] rxd [4];
    logic       rxv [4];

    wire [7:0]  cmd [4];
    wire [7:0]  wd  [4];
    wire        we  [4];
    wire        dn  [4];
    wire        er  [4];
    wire        bs  [4];
    wire [1:0]  ec  [4];
    wire [15:0] wa  [4];

    wire [7:0]  wa0, wa1, wa3;
    wire [8:0]  wa2;
    wire [8:0]  ln0, ln1, ln3;
    wire [15:0] ln2;

    assign wa[0] = {8'h00, wa0};
    assign wa[1] = {8'h00, wa1};
    assign wa[2] = {7'h00, wa2};
    assign wa[3] = {8'h00, wa3};

    rx_packet_parser u_a (
        .clk(clk), .reset_n(reset_n), .rx_data(rxd[0]), .rx_valid(rxv[0]),
        .cmd_rx(cmd[0]), .len_rx(ln0), .wr_data(wd[0]), .wr_addr(wa0), .we(we[0]),
        .pck_done(dn[0]), .pck_err(er[0]), .err_code(ec[0]), .busy(bs[0])
    );

    rx_packet_parser #(.TIMEOUT_CYC(100)) u_b (
        .clk(clk), .reset_n(reset_n), .rx_data(rxd[1]), .rx_valid(rxv[1]),
        .cmd_rx(cmd[1]), .len_rx(ln1), .wr_data(wd[1]), .wr_addr(wa1), .we(we[1]),
        .pck_done(dn[1]), .pck_err(er[1]), .err_code(ec[1]), .busy(bs[1])
    );

    rx_packet_parser #(.MAX_LEN(300), .LEN_BYTES(2), .TIMEOUT_CYC(100)) u_c (
        .clk(clk), .reset_n(reset_n), .rx_data(rxd[2]), .rx_valid(rxv[2]),
        .cmd_rx(cmd[2]), .len_rx(ln2), .wr_data(wd[2]), .wr_addr(wa2), .we(we[2]),
        .pck_done(dn[2]), .pck_err(er[2]), .err_code(ec[2]), .busy(bs[2])
    );

    rx_packet_parser #(.CHK_MODE(1)) u_d (
        .clk(clk), .reset_n(reset_n), .rx_data(rxd[3]), .rx_valid(rxv[3]),
        .cmd_rx(cmd[3]), .len_rx(ln3), .wr_data(wd[3]), .wr_addr(wa3), .we(we[3]),
        .pck_done(dn[3]), .pck_err(er[3]), .err_code(ec[3]), .busy(bs[3])
    );

    int n_chk = 0;
    int n_err = 0;

    // {inst[1:0], addr[15:0], data[7:0]} and {inst[1:0], done, err, code[1:0]}
    logic [25:0] exp_wr [$];
    logic [5:0]  exp_ev [$];
    logic [25:0] w_e;
    logic [5:0]  v_e;
    logic [7:0]  payload [512];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] upd(input int mode, input logic [7:0] a, input logic [7:0] b);
        return (mode == 1) ? (a ^ b) : (a + b);
    endfunction

    task automatic put(input int k, input logic [7:0] b);
        @(negedge clk);
        rxd[k] = b;
        rxv[k] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) rxv[k] = 1'b0;
        end
    endtask

    task automatic send_frame(input int k, input int mode, input int lenb, input logic [15:0] lenf,
                              input int n, input logic [7:0] c, input bit bad);
        logic [7:0] acc;
        logic [7:0] chk;
        acc = c;
        for (int i = lenb - 1; i >= 0; i--) acc = upd(mode, acc, 8'(lenf >> (8 * i)));
        for (int i = 0; i < n; i++) begin
            acc = upd(mode, acc, payload[i]);
            exp_wr.push_back({2'(k), 16'(i), payload[i]});
        end
        chk = (mode == 1) ? acc : ~acc;
        if (bad) chk = chk ^ 8'h03;
        exp_ev.push_back(bad ? {2'(k), 1'b0, 1'b1, 2'd1} : {2'(k), 1'b1, 1'b0, 2'd0});
        put(k, c);
        for (int i = lenb - 1; i >= 0; i--) put(k, 8'(lenf >> (8 * i)));
        for (int i = 0; i < n; i++) put(k, payload[i]);
        put(k, chk);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                if (exp_wr.size() == 0) begin
                    check_val("we_unexpected", 32'(k), 32'hFF);
                end else begin
                    w_e = exp_wr.pop_front();
                    check_val("wr_inst", 32'(k), 32'(w_e[25:24]));
                    check_val("wr_addr", 32'(wa[k]), 32'(w_e[23:8]));
                    check_val("wr_data", 32'(wd[k]), 32'(w_e[7:0]));
                end
            end
            if (dn[k] || er[k]) begin
                check_val("pulse_excl", 32'(dn[k] & er[k]), 32'd0);
                if (exp_ev.size() == 0) begin
                    check_val("pulse_unexpected", {24'd0, 2'(k), dn[k], er[k], ec[k]}, 32'hFF);
                end else begin
                    v_e = exp_ev.pop_front();
                    check_val("pulse", {26'd0, 2'(k), dn[k], er[k], ec[k]}, {26'd0, v_e});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rxd[k] = 8'h00;
            rxv[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cmd_len", {cmd[0], 7'd0, ln0, wd[0]}, 32'd0);
        check_val("rst_ctl", {18'd0, wa0, we[0], dn[0], er[0], ec[0], bs[0]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic 3-byte frame with additive checksum
        payload[0] = 8'hA0; payload[1] = 8'hA1; payload[2] = 8'hA2;
        send_frame(0, 0, 1, 16'd3, 3, 8'h11, 1'b0);
        idle(3);
        check_val("t1_cmd", 32'(cmd[0]), 32'h11);
        check_val("t1_len", 32'(ln0), 32'd3);
        check_val("t1_busy", 32'(bs[0]), 32'd0);
        check_val("t1_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        // LEN field 0 means a full MAX_LEN payload
        for (int i = 0; i < 256; i++) payload[i] = 8'(i);
        send_frame(0, 0, 1, 16'd0, 256, 8'h5A, 1'b0);
        idle(3);
        check_val("t2_len", 32'(ln0), 32'd256);
        check_val("t2_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        // Bad checksum, then recovery on the next good frame
        payload[0] = 8'hA0; payload[1] = 8'hA1; payload[2] = 8'hA2;
        send_frame(0, 0, 1, 16'd3, 3, 8'h11, 1'b1);
        idle(3);
        check_val("t3_errcode", 32'(ec[0]), 32'd1);
        send_frame(0, 0, 1, 16'd3, 3, 8'h11, 1'b0);
        idle(3);
        check_val("t3_errcode_clr", 32'(ec[0]), 32'd0);
        check_val("t3_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        // Inter-byte timeout mid-payload
        exp_wr.push_back({2'd1, 16'd0, 8'h33});
        exp_wr.push_back({2'd1, 16'd1, 8'h44});
        exp_ev.push_back({2'd1, 1'b0, 1'b1, 2'd3});
        put(1, 8'h22); put(1, 8'h04); put(1, 8'h33); put(1, 8'h44);
        @(posedge clk);
        #1 rxv[1] = 1'b0;
        check_val("t4_busy_idle", 32'(bs[1]), 32'd1);
        check_val("t4_len", 32'(ln1), 32'd4);
        cyc = 0;
        while (!er[1] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("t4_to_latency", 32'(cyc), 32'd100);
        check_val("t4_errcode", 32'(ec[1]), 32'd3);
        @(posedge clk);
        #1;
        check_val("t4_busy_drop", 32'(bs[1]), 32'd0);
        idle(2);
        check_val("t4_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        // Oversize two-byte LEN: error, payload skipped until timeout, no second pulse
        exp_ev.push_back({2'd2, 1'b0, 1'b1, 2'd2});
        put(2, 8'h55); put(2, 8'h01); put(2, 8'h2D);
        for (int i = 0; i < 4; i++) put(2, 8'(8'h10 + i));
        @(posedge clk);
        #1 rxv[2] = 1'b0;
        check_val("t5_skip_busy", 32'(bs[2]), 32'd1);
        cyc = 0;
        while (bs[2] && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("t5_skip_exit", 32'(cyc), 32'd100);
        check_val("t5_errcode", 32'(ec[2]), 32'd2);
        check_val("t5_len", 32'(ln2), 32'd0);
        idle(5);
        check_val("t5_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        // XOR checksum, back-to-back frames, then reset mid-payload
        payload[0] = 8'hA0; payload[1] = 8'hA1; payload[2] = 8'hA2;
        send_frame(3, 1, 1, 16'd3, 3, 8'h31, 1'b0);
        for (int i = 0; i < 5; i++) payload[i] = 8'(8'hC0 + i);
        send_frame(3, 1, 1, 16'd5, 5, 8'h32, 1'b0);
        idle(3);
        check_val("t6_cmd", 32'(cmd[3]), 32'h32);
        check_val("t6_len", 32'(ln3), 32'd5);
        check_val("t6_drain", 32'(exp_wr.size() + exp_ev.size()), 32'd0);
        exp_wr.push_back({2'd3, 16'd0, 8'h77});
        exp_wr.push_back({2'd3, 16'd1, 8'h78});
        put(3, 8'h33); put(3, 8'h06); put(3, 8'h77); put(3, 8'h78);
        idle(1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_val("t6_rst_cmd_len", {cmd[3], 7'd0, ln3, wd[3]}, 32'd0);
        check_val("t6_rst_ctl", {18'd0, wa3, we[3], dn[3], er[3], ec[3], bs[3]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(20);
        check_val("t6_post_rst_busy", 32'(bs[3]), 32'd0);
        check_val("t6_drain_final", 32'(exp_wr.size() + exp_ev.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
